two_input_func_sequencer: RTL and testbench
===========================================

// Module: two_input_func_sequencer
// PURPOSE
//  Initiator/front end for the single-input y=0.5x+x^2*cos((x-128)/128) evaluator.
//  Accepts a Nios-style multi-cycle custom instruction carrying x1 (dataa) and x2 (datab).
//  Issues two start/done transactions to one evaluator instance, then one to a float adder.
//  Returns f(x1)+f(x2) with a single-cycle done.
//  Sits between the CPU custom-instruction slot and the evaluator/adder pair.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          max cycles waiting on any unit done; 1..65535
//  NAN_VALUE       32'h7FC00000  result driven on timeout
// PORTS
//  clk         in   1   system clock; single clock domain
//  reset       in   1   synchronous, active-high
//  clk_en      in   1   CPU clock enable; when 0, all state/counters hold
//  start       in   1   one-cycle request, sampled only when clk_en=1
//  dataa       in   32  x1, IEEE-754 single, valid in start cycle only
//  datab       in   32  x2, IEEE-754 single, valid in start cycle only
//  result      out  32  f(x1)+f(x2), valid when done=1, held until next accepted start
//  done        out  1   one-cycle completion pulse
//  err         out  1   1 = last op timed out; updated with done
//  eval_start  out  1   one-cycle pulse to evaluator
//  eval_data   out  32  evaluator operand, stable from eval_start until eval_done
//  eval_result in   32  evaluator output, sampled in eval_done cycle
//  eval_done   in   1   evaluator completion pulse
//  add_enable  out  1   adder enable, level, held high until add_done sampled
//  add_a       out  32  f(x1), stable while add_enable=1
//  add_b       out  32  f(x2), stable while add_enable=1
//  add_result  in   32  sum, sampled in add_done cycle
//  add_done    in   1   adder completion pulse
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter=0, captured operands cleared.
//  FSM (advances only when clk_en=1):
//   IDLE -start-> E1 (capture dataa/datab) ; E1: eval_start=1, eval_data=x1 -> W1
//   W1 -eval_done-> E2 (latch f1)          ; E2: eval_start=1, eval_data=x2 -> W2
//   W2 -eval_done-> AD (latch f2)          ; AD: add_enable=1 -> WA
//   WA -add_done-> FIN (latch sum)         ; FIN: done=1, err=0 -> IDLE
//  - Latency with evaluator delay Le and adder delay La is 2*Le+La+4 cycles (start->done).
//    Le = cycles from eval_start to eval_done; La = cycles from add_enable rise to add_done.
//  - eval_done seen in an E state (same cycle as eval_start) is stale: ignore it.
//    Likewise ignore add_done seen in AD.
//  - start while not IDLE: ignored; captured operands unchanged.
//  - start and FIN in same cycle: FIN completes; start ignored (CPU never overlaps).
//  - Timeout: counter clears on entry to W1/W2/WA and increments each clk_en cycle there.
//    On reaching TIMEOUT_CYCLES: result=NAN_VALUE, err=1, done pulse, eval/add outputs low.
//    FSM returns to IDLE. A late done pulse arriving in IDLE is ignored.
//  - No arithmetic performed locally; values pass bit-exact.
//  - reset mid-operation: at next edge all outputs 0, FSM IDLE, no done emitted.
// STRUCTURE
//  Shared package: FSM state encoding, NAN_VALUE, IEEE constants 1.0/2.0/3.0 for benches.
//  One natural sub-module: handshake_timeout_counter.
//   Inputs: clear, count enable. Output: expired flag.
//   Reused by the three wait states.
//  Evaluator and adder are instantiated by the parent, not inside this block.
// TESTING
//  Bench models: evaluator Le=10, returns 1.0 for x1, 2.0 for x2; adder La=5, real add.
//  1 start x1=0x3F800000, x2=0x40000000 at cycle 0.
//    -> eval_start at cycles 1 and 12; add_enable rises at 23.
//    -> done at 29; result 0x40400000; err 0.
//  2 clk_en low for 7 cycles during W2.
//    -> done delayed exactly 7 cycles; result unchanged.
//  3 evaluator model never answers for x2, TIMEOUT_CYCLES=16.
//    -> done once, result 0x7FC00000, err 1.
//    -> a following op completes normally with err 0.
//  4 second start pulse at cycle 5 with different data -> ignored; result still 0x40400000.
//  5 reset asserted at cycle 15 -> next cycle all outputs 0; no done.
//    -> a new start then completes in 29 cycles.
//  6 stale eval_done held high during E1 -> not accepted; W1 still waits Le cycles.

Source files
------------

// File: rtl/two_input_func_sequencer_pkg.sv
// Shared definitions for the two-operand evaluator sequencer: FSM encoding,
// the timeout result value and a few IEEE-754 single constants for benches.
package two_input_func_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_W1   = 3'd2,
        ST_E2   = 3'd3,
        ST_W2   = 3'd4,
        ST_AD   = 3'd5,
        ST_WA   = 3'd6,
        ST_FIN  = 3'd7
    } seq_state_t;

    localparam logic [31:0] NAN_VALUE_DEFAULT = 32'h7FC0_0000;
    localparam logic [31:0] FP_ONE            = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO            = 32'h4000_0000;
    localparam logic [31:0] FP_THREE          = 32'h4040_0000;

endpackage

// File: rtl/handshake_timeout_counter.sv
// Wait-cycle counter shared by the three handshake wait states; flags the
// cycle in which the TIMEOUT_CYCLES-th enabled wait cycle is being spent.
module handshake_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign expired = count_en && (count_reg == LAST_COUNT);

endmodule

// File: rtl/two_input_func_sequencer.sv
// Custom-instruction front end: evaluates f(x1) and f(x2) on one shared
// evaluator, sums them on an external adder and returns the sum with done.
module two_input_func_sequencer
    import two_input_func_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] NAN_VALUE      = NAN_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        err,
    output logic        eval_start,
    output logic [31:0] eval_data,
    input  logic [31:0] eval_result,
    input  logic        eval_done,
    output logic        add_enable,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_result,
    input  logic        add_done
);

    seq_state_t  state_reg, state_next;
    logic [31:0] x1_reg, x2_reg, f1_reg, f2_reg, result_reg;
    logic        err_reg;
    logic        in_wait, arm_wait, expired, fin_ok, fin_timeout;

    assign in_wait  = (state_reg == ST_W1) || (state_reg == ST_W2) || (state_reg == ST_WA);
    assign arm_wait = (state_reg == ST_E1) || (state_reg == ST_E2) || (state_reg == ST_AD);

    handshake_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (clk_en && arm_wait),
        .count_en(clk_en && in_wait),
        .expired (expired)
    );

    // Completion pulses seen in the issuing E/AD cycle are stale, so only
    // the wait states look at eval_done/add_done.
    always_comb begin
        state_next  = state_reg;
        fin_ok      = 1'b0;
        fin_timeout = 1'b0;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_E1;
            ST_E1:   state_next = ST_W1;
            ST_W1: begin
                if (eval_done) state_next = ST_E2;
                else if (expired) begin state_next = ST_FIN; fin_timeout = 1'b1; end
            end
            ST_E2:   state_next = ST_W2;
            ST_W2: begin
                if (eval_done) state_next = ST_AD;
                else if (expired) begin state_next = ST_FIN; fin_timeout = 1'b1; end
            end
            ST_AD:   state_next = ST_WA;
            ST_WA: begin
                if (add_done) begin state_next = ST_FIN; fin_ok = 1'b1; end
                else if (expired) begin state_next = ST_FIN; fin_timeout = 1'b1; end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            x1_reg     <= '0;
            x2_reg     <= '0;
            f1_reg     <= '0;
            f2_reg     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else if (clk_en) begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                x1_reg <= dataa;
                x2_reg <= datab;
            end
            if (state_reg == ST_W1 && eval_done) f1_reg <= eval_result;
            if (state_reg == ST_W2 && eval_done) f2_reg <= eval_result;
            if (fin_ok) begin
                result_reg <= add_result;
                err_reg    <= 1'b0;
            end else if (fin_timeout) begin
                result_reg <= NAN_VALUE;
                err_reg    <= 1'b1;
            end
        end
    end

    always_comb begin
        eval_data = '0;
        case (state_reg)
            ST_E1, ST_W1: eval_data = x1_reg;
            ST_E2, ST_W2: eval_data = x2_reg;
            default:      eval_data = '0;
        endcase
    end

    // Pulses are qualified by clk_en so a stalled CPU never sees them twice.
    assign eval_start = clk_en && ((state_reg == ST_E1) || (state_reg == ST_E2));
    assign add_enable = (state_reg == ST_AD) || (state_reg == ST_WA);
    assign add_a      = add_enable ? f1_reg : '0;
    assign add_b      = add_enable ? f2_reg : '0;
    assign done       = clk_en && (state_reg == ST_FIN);
    assign result     = result_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_two_input_func_sequencer.sv
// Directed bench: evaluator model (Le=10, 1.0 for x1 / 2.0 for x2) and
// adder model (La=5, real add) around the sequencer with a 16-cycle timeout.
module tb_two_input_func_sequencer;
    import two_input_func_sequencer_pkg::*;

    localparam int LE = 10;
    localparam int LA = 5;

    logic        clk = 1'b0;
    logic        reset, clk_en, start, done, err, eval_start, eval_done, add_enable, add_done;
    logic [31:0] dataa, datab, result, eval_data, eval_result, add_a, add_b, add_result;

    int checks = 0;
    int failures = 0;

    // model state
    int          ev_timer = 0;
    int          add_timer = 0;
    bit          add_armed = 0;
    logic [31:0] ev_res = '0;
    logic [31:0] add_sum = '0;
    logic [31:0] op_x1, op_x2;

    // per-operation observations
    int          n_done, done_at, n_es, add_rise;
    logic [31:0] res_at_done, es_dat [4], rise_a, rise_b;
    int          es_cyc [4];
    logic        err_at_done, add_prev;
    logic [134:0] rst_snap;

    always #5 clk = ~clk;

    two_input_func_sequencer #(
        .TIMEOUT_CYCLES(16),
        .NAN_VALUE     (32'h7FC0_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .result     (result),
        .done       (done),
        .err        (err),
        .eval_start (eval_start),
        .eval_data  (eval_data),
        .eval_result(eval_result),
        .eval_done  (eval_done),
        .add_enable (add_enable),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_done   (add_done)
    );

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = 11'(int'(b[30:23]) + 896);
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    // One operation: start at relative cycle 0, run for budget cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int budget,
                         input int stall_at, input int stall_len, input int extra_at,
                         input int reset_at, input bit stale_e1, input bit drop_x2);
        n_done = 0; done_at = -1; n_es = 0; add_rise = -1; add_prev = 1'b0;
        res_at_done = 'x; err_at_done = 1'bx; rst_snap = 'x;
        op_x1 = a; op_x2 = b;
        for (int rel = 0; rel < budget; rel++) begin
            start  = (rel == 0) || (rel == extra_at);
            dataa  = (rel == 0) ? a : ((rel == extra_at) ? 32'h40A0_0000 : 32'hDEAD_BEEF);
            datab  = (rel == 0) ? b : ((rel == extra_at) ? 32'h40C0_0000 : 32'hDEAD_BEEF);
            clk_en = !(rel >= stall_at && rel < stall_at + stall_len);
            reset  = (rel == reset_at);
            eval_done   = (ev_timer == 1) || (stale_e1 && rel == 1);
            eval_result = (stale_e1 && rel == 1) ? 32'hFFFF_FFFF : ev_res;
            add_done    = (add_timer == 1);
            add_result  = add_sum;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_at < 0) begin done_at = rel; res_at_done = result; err_at_done = err; end
            end
            if (clk_en && eval_start && n_es < 4) begin
                es_cyc[n_es] = rel; es_dat[n_es] = eval_data; n_es++;
            end
            if (add_enable && !add_prev && add_rise < 0) begin
                add_rise = rel; rise_a = add_a; rise_b = add_b;
            end
            add_prev = add_enable;
            if (rel == reset_at + 1)
                rst_snap = {done, err, eval_start, add_enable, add_done, result, eval_data, add_a, add_b};
            if (clk_en) begin
                if (ev_timer > 0) ev_timer--;
                if (eval_start) begin
                    ev_res = (eval_data == op_x1) ? FP_ONE : FP_TWO;
                    if (!(drop_x2 && eval_data == op_x2)) ev_timer = LE;
                end
                if (add_timer > 0) add_timer--;
                if (add_enable && !add_armed) begin
                    add_armed = 1; add_timer = LA; add_sum = r2f(f2r(add_a) + f2r(add_b));
                end
                if (!add_enable) add_armed = 0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; clk_en = 1'b1; reset = 1'b0; eval_done = 1'b0; add_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({done, err, eval_start, add_enable} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {done, err, eval_start, add_enable}); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if ({eval_data, add_a, add_b} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {eval_data, add_a, add_b}); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_op(FP_ONE, FP_TWO, 40, 1000, 0, -1, -1, 0, 0);
        checks++; if (done_at !== 29) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=29", done_at); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        checks++; if (res_at_done !== FP_THREE) begin failures++; $display("FAIL basic_result got=%h exp=%h", res_at_done, FP_THREE); end
        checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_at_done); end
        checks++; if (es_cyc[0] !== 1 || es_cyc[1] !== 12) begin failures++; $display("FAIL basic_eval_start got=%0d,%0d exp=1,12", es_cyc[0], es_cyc[1]); end
        checks++; if (es_dat[0] !== FP_ONE || es_dat[1] !== FP_TWO) begin failures++; $display("FAIL basic_eval_data got=%h,%h exp=%h,%h", es_dat[0], es_dat[1], FP_ONE, FP_TWO); end
        checks++; if (add_rise !== 23) begin failures++; $display("FAIL basic_add_rise got=%0d exp=23", add_rise); end
        checks++; if (rise_a !== FP_ONE || rise_b !== FP_TWO) begin failures++; $display("FAIL basic_add_ops got=%h,%h exp=%h,%h", rise_a, rise_b, FP_ONE, FP_TWO); end
        checks++; if (result !== FP_THREE) begin failures++; $display("FAIL basic_result_held got=%h exp=%h", result, FP_THREE); end
    endtask

    task automatic test_stall();
        do_op(FP_ONE, FP_TWO, 45, 15, 7, -1, -1, 0, 0);
        checks++; if (done_at !== 36) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=36", done_at); end
        checks++; if (res_at_done !== FP_THREE || n_done !== 1) begin failures++; $display("FAIL stall_result got=%h/%0d exp=%h/1", res_at_done, n_done, FP_THREE); end
    endtask

    task automatic test_timeout();
        do_op(FP_ONE, FP_TWO, 50, 1000, 0, -1, -1, 0, 1);
        checks++; if (n_done !== 1) begin failures++; $display("FAIL timeout_done_count got=%0d exp=1", n_done); end
        checks++; if (done_at !== 29) begin failures++; $display("FAIL timeout_done_cycle got=%0d exp=29", done_at); end
        checks++; if (res_at_done !== 32'h7FC0_0000) begin failures++; $display("FAIL timeout_result got=%h exp=7fc00000", res_at_done); end
        checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err_at_done); end
        checks++; if (add_rise !== -1) begin failures++; $display("FAIL timeout_add_rise got=%0d exp=-1", add_rise); end
        do_op(FP_ONE, FP_TWO, 40, 1000, 0, -1, -1, 0, 0);
        checks++; if (done_at !== 29 || res_at_done !== FP_THREE) begin failures++; $display("FAIL recover_op got=%0d/%h exp=29/%h", done_at, res_at_done, FP_THREE); end
        checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL recover_err got=%b exp=0", err_at_done); end
    endtask

    task automatic test_ignore_start();
        do_op(FP_ONE, FP_TWO, 40, 1000, 0, 5, -1, 0, 0);
        checks++; if (done_at !== 29 || n_done !== 1) begin failures++; $display("FAIL busy_start_done got=%0d/%0d exp=29/1", done_at, n_done); end
        checks++; if (res_at_done !== FP_THREE) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", res_at_done, FP_THREE); end
        checks++; if (es_dat[1] !== FP_TWO) begin failures++; $display("FAIL busy_start_x2 got=%h exp=%h", es_dat[1], FP_TWO); end
    endtask

    task automatic test_reset_mid();
        do_op(FP_ONE, FP_TWO, 50, 1000, 0, -1, 15, 0, 0);
        checks++; if (rst_snap !== 135'd0) begin failures++; $display("FAIL midreset_outputs got=%h exp=0", rst_snap); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", n_done); end
        do_op(FP_ONE, FP_TWO, 40, 1000, 0, -1, -1, 0, 0);
        checks++; if (done_at !== 29 || res_at_done !== FP_THREE) begin failures++; $display("FAIL midreset_next_op got=%0d/%h exp=29/%h", done_at, res_at_done, FP_THREE); end
    endtask

    task automatic test_stale_done();
        do_op(FP_ONE, FP_TWO, 40, 1000, 0, -1, -1, 1, 0);
        checks++; if (n_es < 2 || es_cyc[1] !== 12) begin failures++; $display("FAIL stale_second_eval got=%0d exp=12", es_cyc[1]); end
        checks++; if (done_at !== 29) begin failures++; $display("FAIL stale_done_cycle got=%0d exp=29", done_at); end
        checks++; if (res_at_done !== FP_THREE) begin failures++; $display("FAIL stale_result got=%h exp=%h", res_at_done, FP_THREE); end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0; datab = '0;
        eval_result = '0; eval_done = 1'b0; add_result = '0; add_done = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_stale_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
